// File: rtl/ex_latch_dump.sv
// Debug read-out of the EX-side ID/EX latch: snapshots all latch outputs on request
// and streams them as a 25-byte framed, XOR-checksummed sequence over valid/ready.
module ex_latch_dump #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dump_req,
  input  logic [31:0] ex_dato_1,
  input  logic [31:0] ex_dato_2,
  input  logic [31:0] ex_extended_beq_offset,
  input  logic [31:0] ex_pc_plus_8,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic [5:0]  ex_function_code,
  input  logic [3:0]  ex_alu_op,
  input  logic [2:0]  ex_bhw_type,
  input  logic        ex_reg_dst,
  input  logic        ex_alu_src,
  input  logic        ex_m_mem_read,
  input  logic        ex_m_mem_write,
  input  logic        ex_wb_mem_to_reg,
  input  logic        ex_wb_reg_write,
  input  logic        ex_isJal,
  input  logic        ex_jalSel,
  input  logic        ex_halt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  localparam logic [4:0] LAST_IDX = 5'd24;
  localparam logic [4:0] CSUM_SRC_LAST = 5'd23;

  logic [0:0]   r_state;
  logic [4:0]   r_idx;
  logic [7:0]   r_csum;
  logic [164:0] r_snap;
  logic [7:0]   r_tx_data;
  logic         r_tx_valid;
  logic         r_busy;
  logic         r_done;

  logic [164:0] w_capture;
  logic [4:0]   w_next_idx;
  logic [7:0]   w_next_byte;
  logic         w_fire;

  // Snapshot layout, MSB first, matches the byte order of the frame body.
  assign w_capture = {ex_dato_1, ex_dato_2, ex_extended_beq_offset, ex_pc_plus_8,
                      ex_rs, ex_rt, ex_rd, ex_function_code, ex_bhw_type, ex_alu_op,
                      ex_reg_dst, ex_alu_src, ex_m_mem_read, ex_m_mem_write,
                      ex_wb_mem_to_reg, ex_wb_reg_write, ex_isJal, ex_jalSel, ex_halt};

  function automatic logic [7:0] frame_byte(input logic [164:0] snap, input logic [4:0] idx);
    logic [7:0]   shamt;
    logic [164:0] shifted;
    frame_byte = 8'h00;
    shamt      = 8'd157 - {idx - 5'd1, 3'b000};
    shifted    = snap >> shamt;
    case (idx)
      5'd17:   frame_byte = {3'b000, snap[36:32]};
      5'd18:   frame_byte = {3'b000, snap[31:27]};
      5'd19:   frame_byte = {3'b000, snap[26:22]};
      5'd20:   frame_byte = {2'b00, snap[21:16]};
      5'd21:   frame_byte = {1'b0, snap[15:9]};
      5'd22:   frame_byte = snap[8:1];
      5'd23:   frame_byte = {7'b0000000, snap[0]};
      default: begin
        // Bytes 1..16 are the four 32-bit words, sliced straight out of the snapshot.
        if ((idx >= 5'd1) && (idx <= 5'd16)) begin
          frame_byte = shifted[7:0];
        end else begin
          frame_byte = 8'h00;
        end
      end
    endcase
  endfunction

  // Next byte to present; the trailer folds in byte 23 as it leaves.
  always_comb begin
    w_next_idx  = r_idx + 5'd1;
    w_next_byte = 8'h00;
    if (r_idx == CSUM_SRC_LAST) begin
      w_next_byte = r_csum ^ r_tx_data;
    end else begin
      w_next_byte = frame_byte(r_snap, w_next_idx);
    end
  end

  assign w_fire = r_tx_valid & tx_ready;

  // Frame sequencer: capture, byte stepping, checksum accumulation and done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 5'd0;
      r_csum     <= 8'h00;
      r_snap     <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_snap     <= w_capture;
            r_idx      <= 5'd0;
            r_csum     <= 8'h00;
            r_tx_data  <= HEADER;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_fire) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= S_IDLE;
              r_idx      <= 5'd0;
              r_tx_data  <= 8'h00;
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              // Header is excluded from the checksum.
              if (r_idx != 5'd0) begin
                r_csum <= r_csum ^ r_tx_data;
              end
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_idx      <= 5'd0;
          r_tx_data  <= 8'h00;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
